triple_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 3x multiplier datapath (result = 3*a, 4-bit in, 6-bit out) among NUM_REQ requesters.
- Each requester has a valid/ready request port. One response channel returns the result tagged with the requester ID.
- Sits between the requesting blocks and the shared tripler. The tripler is implemented internally as a + (a<<1) and registered.

---
 rtl/triple_arbiter.sv | 116 +++++++++++
 tb/tb_triple_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/triple_arbiter.sv
// triple_arbiter: round-robin arbiter that shares one registered 3x datapath
// (result = a + (a << 1)) among NUM_REQ valid/ready requesters. Each accepted
// operand goes IDLE -> CALC -> RESP and comes back tagged with its requester ID.
// Optional feature: define TRIPLE_ARB_CNT_EN to add the 8-bit done_count output,
// which counts completed response handshakes and wraps 255 -> 0.
module triple_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 4,
  parameter int R_W     = A_W + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [R_W-1:0]         rsp_result,
  output logic                   busy
`ifdef TRIPLE_ARB_CNT_EN
  ,
  output logic [7:0]             done_count
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_reg;
  logic [ID_W-1:0] grant_id;
  logic            grant_any;
  logic [A_W-1:0]  a_reg;
  logic [R_W-1:0]  result_reg;
  logic            accept;
  logic            rsp_fire;
  int              scan_idx;
  logic [ID_W-1:0] scan_id;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_id = scan_idx[ID_W-1:0];
      if (!grant_any && req_valid[scan_id]) begin
        grant_any = 1'b1;
        grant_id  = scan_id;
      end
    end
  end

  assign accept   = (state == IDLE) && grant_any;
  assign rsp_fire = (state == RESP) && rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: one pass through the datapath per accepted request.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: the grant strobe is only visible in IDLE and never during reset.
  always_comb begin
    req_ready = '0;
    if ((state == IDLE) && rst_n && grant_any) req_ready[grant_id] = 1'b1;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
    rsp_id     = id_reg;
    rsp_result = result_reg;
  end

  // Operand capture, pointer advance and the registered tripler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      id_reg     <= '0;
      rr_ptr     <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        a_reg  <= req_a[grant_id*A_W +: A_W];
        id_reg <= grant_id;
        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
      end
      if (state == CALC) result_reg <= R_W'(a_reg) + (R_W'(a_reg) << 1);
    end
  end

`ifdef TRIPLE_ARB_CNT_EN
  // Completed-response counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        done_count <= '0;
    else if (rsp_fire) done_count <= done_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_triple_arbiter.sv
// tb_triple_arbiter: directed, self-checking bench for triple_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_triple_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_result;
  logic        busy;
`ifdef TRIPLE_ARB_CNT_EN
  logic [7:0]  done_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  triple_arbiter #(.NUM_REQ(4), .ID_W(2), .A_W(4), .R_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
`ifdef TRIPLE_ARB_CNT_EN
    ,
    .done_count (done_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b0000;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_a = 16'hFFFF;
    rsp_ready = 1'b1;
    #2;
    compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    compared++; if (rsp_id !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    compared++; if (rsp_result !== 6'd0) begin mismatched++; $display("[TB] FAIL reset_rsp_result: got %0d expected 0", rsp_result); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    #1;
    compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_hold_req_ready: got %b expected 0000", req_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hold_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0001;
    req_a = 16'h0005;
    rsp_ready = 1'b1;
    #1;
    compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("[TB] FAIL single_grant: got %b expected 0001", req_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_idle_busy: got %b expected 0", busy); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL single_calc_ready: got %b expected 0000", req_ready); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_calc_busy: got %b expected 1", busy); end
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_calc_valid: got %b expected 0", rsp_valid); end
    @(negedge clk);
    #1;
    compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
    compared++; if (rsp_id !== 2'd0) begin mismatched++; $display("[TB] FAIL single_rsp_id: got %0d expected 0", rsp_id); end
    compared++; if (rsp_result !== 6'd15) begin mismatched++; $display("[TB] FAIL single_rsp_result: got %0d expected 15", rsp_result); end
    @(negedge clk);
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_rsp_done: got %b expected 0", rsp_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_back_idle: got %b expected 0", busy); end
  endtask

  task automatic test_all_four();
    logic [5:0] exp_res [4];
    logic [3:0] exp_ready;
    exp_res[0] = 6'd0;
    exp_res[1] = 6'd3;
    exp_res[2] = 6'd30;
    exp_res[3] = 6'd45;
    do_reset();
    @(negedge clk);
    req_valid = 4'b1111;
    req_a = {4'd15, 4'd10, 4'd1, 4'd0};
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_ready = 4'b0001 << i;
      compared++; if (req_ready !== exp_ready) begin mismatched++; $display("[TB] FAIL all4_grant[%0d]: got %b expected %b", i, req_ready, exp_ready); end
      @(negedge clk);
      req_valid[i] = 1'b0;
      #1;
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL all4_busy[%0d]: got %b expected 1", i, busy); end
      @(negedge clk);
      #1;
      compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL all4_valid[%0d]: got %b expected 1", i, rsp_valid); end
      compared++; if (rsp_id !== 2'(i)) begin mismatched++; $display("[TB] FAIL all4_id[%0d]: got %0d expected %0d", i, rsp_id, i); end
      compared++; if (rsp_result !== exp_res[i]) begin mismatched++; $display("[TB] FAIL all4_result[%0d]: got %0d expected %0d", i, rsp_result, exp_res[i]); end
      @(negedge clk);
      #1;
    end
    compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL all4_drained: got %b expected 0000", req_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL all4_idle: got %b expected 0", busy); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ready;
    logic [1:0] exp_id;
    logic [5:0] exp_r;
    @(negedge clk);
    req_valid = 4'b1001;
    req_a = {4'd9, 4'd0, 4'd0, 4'd2};
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_ready = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      exp_id    = (i % 2 == 0) ? 2'd0 : 2'd3;
      exp_r     = (i % 2 == 0) ? 6'd6 : 6'd27;
      compared++; if (req_ready !== exp_ready) begin mismatched++; $display("[TB] FAIL fair_grant[%0d]: got %b expected %b", i, req_ready, exp_ready); end
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      compared++; if (rsp_id !== exp_id) begin mismatched++; $display("[TB] FAIL fair_id[%0d]: got %0d expected %0d", i, rsp_id, exp_id); end
      compared++; if (rsp_result !== exp_r) begin mismatched++; $display("[TB] FAIL fair_result[%0d]: got %0d expected %0d", i, rsp_result, exp_r); end
      @(negedge clk);
      #1;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 4'b0010;
    req_a = {4'd0, 4'd3, 4'd7, 4'd0};
    rsp_ready = 1'b0;
    #1;
    compared++; if (req_ready !== 4'b0010) begin mismatched++; $display("[TB] FAIL bp_grant: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL bp_calc_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, rsp_valid); end
      compared++; if (rsp_id !== 2'd1) begin mismatched++; $display("[TB] FAIL bp_id[%0d]: got %0d expected 1", i, rsp_id); end
      compared++; if (rsp_result !== 6'd21) begin mismatched++; $display("[TB] FAIL bp_result[%0d]: got %0d expected 21", i, rsp_result); end
      compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0000", i, req_ready); end
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid_at_ready: got %b expected 1", rsp_valid); end
    @(negedge clk);
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_complete: got %b expected 0", rsp_valid); end
    compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("[TB] FAIL bp_next_grant: got %b expected 0100", req_ready); end
    req_valid = 4'b0000;
    #1;
    compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL drop_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_no_txn: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 4'b0100;
    req_a = {4'd0, 4'd11, 4'd0, 4'd0};
    rsp_ready = 1'b0;
    #1;
    compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("[TB] FAIL rmid_grant: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    @(negedge clk);
    #1;
    compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid_valid: got %b expected 1", rsp_valid); end
    compared++; if (rsp_result !== 6'd33) begin mismatched++; $display("[TB] FAIL rmid_result: got %0d expected 33", rsp_result); end
    #1;
    rst_n = 1'b0;
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_async_valid: got %b expected 0", rsp_valid); end
    compared++; if (rsp_result !== 6'd0) begin mismatched++; $display("[TB] FAIL rmid_async_result: got %0d expected 0", rsp_result); end
    compared++; if (rsp_id !== 2'd0) begin mismatched++; $display("[TB] FAIL rmid_async_id: got %0d expected 0", rsp_id); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_async_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_no_rsp: got %b expected 0", rsp_valid); end
    req_valid = 4'b1111;
    req_a = 16'h0000;
    #1;
    compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("[TB] FAIL rmid_ptr_restart: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

`ifdef TRIPLE_ARB_CNT_EN
  task automatic test_count();
    do_reset();
    #1;
    compared++; if (done_count !== 8'd0) begin mismatched++; $display("[TB] FAIL count_reset: got %0d expected 0", done_count); end
    req_valid = 4'b0001;
    req_a = 16'h0001;
    rsp_ready = 1'b1;
    repeat (257 * 3) @(negedge clk);
    req_valid = 4'b0000;
    #1;
    compared++; if (done_count !== 8'd1) begin mismatched++; $display("[TB] FAIL count_wrap: got %0d expected 1", done_count); end
    do_reset();
    #1;
    compared++; if (done_count !== 8'd0) begin mismatched++; $display("[TB] FAIL count_rereset: got %0d expected 0", done_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef TRIPLE_ARB_CNT_EN
    test_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
